// File: rtl/yin_tau_search_if.sv
// Handshake and result bundle between a dt' producer and the YIN tau search block.
// The master side feeds search settings and samples; the slave side returns the result.
interface yin_tau_search_if #(
    parameter int INTERMEDIATE_DATA_WIDTH = 64,
    parameter int TAU_BITS                = 8
);
    logic                               start;
    logic                               mode;
    logic [7:0]                         thr_pct;
    logic [INTERMEDIATE_DATA_WIDTH-1:0] average;
    logic                               dval_valid;
    logic [INTERMEDIATE_DATA_WIDTH-1:0] dval;
    logic                               dval_ready;
    logic                               busy;
    logic                               done;
    logic                               periodic;
    logic [TAU_BITS-1:0]                min_tau;
    logic [INTERMEDIATE_DATA_WIDTH-1:0] min_val;

    modport master (
        output start, mode, thr_pct, average, dval_valid, dval,
        input  dval_ready, busy, done, periodic, min_tau, min_val
    );

    modport slave (
        input  start, mode, thr_pct, average, dval_valid, dval,
        output dval_ready, busy, done, periodic, min_tau, min_val
    );
endinterface

// File: rtl/yin_tau_search.sv
// Streams MAX_TAU dt' samples and picks the YIN period estimate: the first threshold dip
// (mode 0), the local minimum following that dip (mode 1), or the global minimum if no dip occurs.
module yin_tau_search #(
    parameter int INTERMEDIATE_DATA_WIDTH = 64,
    parameter int MAX_TAU                 = 40,
    parameter int MIN_TAU                 = 2,
    parameter int TAU_BITS                = 8
) (
    input logic            clk,
    input logic            reset,
    yin_tau_search_if.slave bus
);
    localparam int LP_PW = INTERMEDIATE_DATA_WIDTH + 8;
    localparam logic [TAU_BITS-1:0] LP_MIN_IDX  = TAU_BITS'(MIN_TAU);
    localparam logic [TAU_BITS-1:0] LP_LAST_IDX = TAU_BITS'(MAX_TAU - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DESCEND,
        DRAIN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic                               r_mode;
    logic [7:0]                         r_thrPct;
    logic [INTERMEDIATE_DATA_WIDTH-1:0] r_average;
    logic [TAU_BITS-1:0]                r_idx;

    logic [INTERMEDIATE_DATA_WIDTH-1:0] r_gminVal;
    logic [TAU_BITS-1:0]                r_gminTau;
    logic                               r_gminValid;
    logic [INTERMEDIATE_DATA_WIDTH-1:0] r_candVal;
    logic [TAU_BITS-1:0]                r_candTau;

    logic [TAU_BITS-1:0]                r_minTau;
    logic [INTERMEDIATE_DATA_WIDTH-1:0] r_minVal;
    logic                               r_periodic;

    logic             w_ready;
    logic             w_busy;
    logic             w_done;
    logic             w_accept;
    logic             w_last;
    logic             w_eligible;
    logic             w_pass;
    logic             w_newMin;
    logic             w_below;
    logic [LP_PW-1:0] w_lhs;
    logic [LP_PW-1:0] w_rhs;

    // Both products fit in LP_PW bits, so the compare is exact without any division.
    assign w_lhs      = LP_PW'(bus.dval) * LP_PW'(100);
    assign w_rhs      = LP_PW'(r_average) * LP_PW'(r_thrPct);
    assign w_pass     = (w_lhs < w_rhs);
    assign w_accept   = bus.dval_valid && w_ready;
    assign w_last     = (r_idx == LP_LAST_IDX);
    assign w_eligible = (r_idx >= LP_MIN_IDX);
    assign w_newMin   = !r_gminValid || (bus.dval < r_gminVal);
    assign w_below    = (bus.dval < r_candVal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_nextState = SCAN;
                end
            end
            SCAN: begin
                w_ready = 1'b1;
                if (bus.dval_valid) begin
                    if (w_last) begin
                        w_nextState = DONE;
                    end else if (w_eligible && w_pass) begin
                        w_nextState = r_mode ? DESCEND : DRAIN;
                    end
                end
            end
            DESCEND: begin
                w_ready = 1'b1;
                if (bus.dval_valid) begin
                    if (w_last) begin
                        w_nextState = DONE;
                    end else if (!w_below) begin
                        w_nextState = DRAIN;
                    end
                end
            end
            DRAIN: begin
                w_ready = 1'b1;
                if (bus.dval_valid && w_last) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode      <= 1'b0;
            r_thrPct    <= '0;
            r_average   <= '0;
            r_idx       <= '0;
            r_gminVal   <= '0;
            r_gminTau   <= '0;
            r_gminValid <= 1'b0;
            r_candVal   <= '0;
            r_candTau   <= '0;
            r_minTau    <= '0;
            r_minVal    <= '0;
            r_periodic  <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.start) begin
                r_mode      <= bus.mode;
                r_thrPct    <= bus.thr_pct;
                r_average   <= bus.average;
                r_idx       <= '0;
                r_gminVal   <= '0;
                r_gminTau   <= '0;
                r_gminValid <= 1'b0;
                r_candVal   <= '0;
                r_candTau   <= '0;
                r_minTau    <= '0;
                r_minVal    <= '0;
                r_periodic  <= 1'b0;
            end

            if (w_accept) begin
                r_idx <= r_idx + TAU_BITS'(1);
            end

            // A dip on the very last sample in mode 1 is already its own local minimum.
            if (w_accept && r_state == SCAN && w_eligible) begin
                if (w_pass) begin
                    r_candVal <= bus.dval;
                    r_candTau <= r_idx;
                    if (!r_mode || w_last) begin
                        r_minTau   <= r_idx;
                        r_minVal   <= bus.dval;
                        r_periodic <= 1'b1;
                    end
                end else begin
                    if (w_newMin) begin
                        r_gminVal   <= bus.dval;
                        r_gminTau   <= r_idx;
                        r_gminValid <= 1'b1;
                    end
                    if (w_last) begin
                        r_minTau   <= w_newMin ? r_idx : r_gminTau;
                        r_minVal   <= w_newMin ? bus.dval : r_gminVal;
                        r_periodic <= 1'b0;
                    end
                end
            end

            if (w_accept && r_state == DESCEND) begin
                if (w_below) begin
                    r_candVal <= bus.dval;
                    r_candTau <= r_idx;
                end
                if (!w_below || w_last) begin
                    r_minTau   <= w_below ? r_idx : r_candTau;
                    r_minVal   <= w_below ? bus.dval : r_candVal;
                    r_periodic <= 1'b1;
                end
            end
        end
    end

    assign bus.dval_ready = w_ready;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.periodic   = r_periodic;
    assign bus.min_tau    = r_minTau;
    assign bus.min_val    = r_minVal;
endmodule

// File: tb/tb_yin_tau_search.sv
// Scoreboard bench for yin_tau_search: a reference model predicts each search result at start,
// and a done monitor pops and compares it when the DUT reports.
module tb_yin_tau_search;
    localparam int W        = 64;
    localparam int MAX_TAU  = 40;
    localparam int MIN_TAU  = 2;
    localparam int TAU_BITS = 8;

    typedef struct packed {
        logic [TAU_BITS-1:0] tau;
        logic [W-1:0]        val;
        logic                per;
    } result_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    yin_tau_search_if #(.INTERMEDIATE_DATA_WIDTH(W), .TAU_BITS(TAU_BITS)) bus ();

    yin_tau_search #(
        .INTERMEDIATE_DATA_WIDTH(W),
        .MAX_TAU(MAX_TAU),
        .MIN_TAU(MIN_TAU),
        .TAU_BITS(TAU_BITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    logic [W-1:0] dat [MAX_TAU];
    result_t      sbQueue [$];
    int           compared = 0;
    int           mismatched = 0;
    int           doneCount = 0;

    task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk the samples once for the dip, then follow the descent or fall back to the minimum.
    function automatic result_t model(input bit m, input logic [7:0] thr, input logic [W-1:0] avg);
        result_t     r;
        logic [71:0] rhs;
        int          c;
        int          g;
        bit          found;
        rhs   = 72'(avg) * 72'(thr);
        found = 1'b0;
        c     = 0;
        for (int i = MIN_TAU; i < MAX_TAU; i++) begin
            if (!found && (72'(dat[i]) * 72'(100) < rhs)) begin
                found = 1'b1;
                c     = i;
            end
        end
        if (found) begin
            if (m) begin
                while (c + 1 < MAX_TAU && dat[c+1] < dat[c]) c++;
            end
            r.tau = TAU_BITS'(c);
            r.val = dat[c];
            r.per = 1'b1;
        end else begin
            g = MIN_TAU;
            for (int i = MIN_TAU; i < MAX_TAU; i++) begin
                if (dat[i] < dat[g]) g = i;
            end
            r.tau = TAU_BITS'(g);
            r.val = dat[g];
            r.per = 1'b0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            result_t e;
            doneCount++;
            if (sbQueue.size() == 0) begin
                checkOutput("unexpectedDone", 1, 0);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("minTau", 80'(bus.min_tau), 80'(e.tau));
                checkOutput("minVal", 80'(bus.min_val), 80'(e.val));
                checkOutput("periodic", 80'(bus.periodic), 80'(e.per));
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "Busy"}, 80'(bus.busy), 0);
        checkOutput({tag, "Done"}, 80'(bus.done), 0);
        checkOutput({tag, "Ready"}, 80'(bus.dval_ready), 0);
        checkOutput({tag, "Periodic"}, 80'(bus.periodic), 0);
        checkOutput({tag, "MinTau"}, 80'(bus.min_tau), 0);
        checkOutput({tag, "MinVal"}, 80'(bus.min_val), 0);
    endtask

    // Runs one search; abortAt >= 0 asserts reset once that many samples have been accepted.
    task automatic applyStimulus(input bit m, input logic [7:0] thr, input logic [W-1:0] avg,
                                 input bit gaps, input bit startPulses, input int abortAt);
        int i;
        int guard;
        int doneBefore;
        bit valid;
        bit acc;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.mode    = m;
        bus.thr_pct = thr;
        bus.average = avg;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busyAfterStart", 80'(bus.busy), 1);
        sbQueue.push_back(model(m, thr, avg));
        doneBefore = doneCount;
        i     = 0;
        guard = 0;
        while (i < MAX_TAU && i != abortAt && guard < 5000) begin
            valid          = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.dval_valid = valid;
            bus.dval       = valid ? dat[i] : {W{1'b1}};
            bus.start      = startPulses && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            acc = valid && (bus.dval_ready === 1'b1);
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
        end
        bus.dval_valid = 1'b0;
        bus.start      = 1'b0;
        if (guard >= 5000) checkOutput("feedTimeout", 1, 0);
        if (i == abortAt) begin
            reset = 1'b1;
            #1;
            checkIdleOutputs("abort");
            void'(sbQueue.pop_back());
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            checkOutput("noDoneAfterAbort", 80'(doneCount), 80'(doneBefore));
        end else begin
            // DONE cycle: start here must be ignored and the block must settle in IDLE.
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            checkOutput("doneOneCycleAfterLast", 80'(doneCount), 80'(doneBefore + 1));
            checkOutput("startInDoneIgnored", 80'(bus.busy), 0);
            repeat (2) @(posedge clk);
            #1;
            checkOutput("singleDonePulse", 80'(doneCount), 80'(doneBefore + 1));
        end
    endtask

    task automatic loadPitch();
        dat[0] = 900; dat[1] = 800; dat[2] = 500; dat[3] = 90; dat[4] = 50; dat[5] = 40;
        for (int i = 6; i < MAX_TAU; i++) dat[i] = W'(100 + (i - 6) * 15);
        dat[MAX_TAU-1] = 600;
    endtask

    task automatic loadFlat(input logic [W-1:0] v);
        for (int i = 0; i < MAX_TAU; i++) dat[i] = v;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.mode       = 1'b0;
        bus.thr_pct    = '0;
        bus.average    = '0;
        bus.dval_valid = 1'b0;
        bus.dval       = '0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("postReset");

        loadPitch();
        applyStimulus(1'b0, 8'd10, 64'd1000, 1'b0, 1'b0, -1);
        applyStimulus(1'b1, 8'd10, 64'd1000, 1'b0, 1'b0, -1);

        for (int i = 0; i < MAX_TAU; i++) dat[i] = W'(300 + i);
        dat[7] = 150;
        dat[20] = 150;
        applyStimulus(1'b1, 8'd10, 64'd1000, 1'b0, 1'b0, -1);

        loadFlat(64'd500);
        dat[1] = 50;
        applyStimulus(1'b0, 8'd10, 64'd1000, 1'b0, 1'b0, -1);

        loadPitch();
        applyStimulus(1'b1, 8'd10, 64'd1000, 1'b1, 1'b1, -1);
        applyStimulus(1'b0, 8'd10, 64'd1000, 1'b1, 1'b1, -1);
        applyStimulus(1'b0, 8'd0, 64'd1000, 1'b0, 1'b0, -1);
        applyStimulus(1'b1, 8'd10, 64'd0, 1'b0, 1'b0, -1);

        applyStimulus(1'b0, 8'd10, 64'd1000, 1'b0, 1'b0, 12);
        applyStimulus(1'b0, 8'd10, 64'd1000, 1'b0, 1'b0, -1);

        loadFlat(64'd500);
        dat[4] = 100;
        dat[9] = 99;
        applyStimulus(1'b0, 8'd10, 64'd1000, 1'b0, 1'b0, -1);

        loadFlat(64'd500);
        dat[MAX_TAU-1] = 10;
        applyStimulus(1'b1, 8'd10, 64'd1000, 1'b0, 1'b0, -1);

        for (int i = 0; i < MAX_TAU; i++) dat[i] = W'(400 - 10 * i);
        applyStimulus(1'b1, 8'd10, 64'd1000, 1'b0, 1'b0, -1);
        applyStimulus(1'b0, 8'd10, 64'd1000, 1'b1, 1'b0, -1);

        for (int i = 0; i < MAX_TAU; i++) dat[i] = 64'hFFFF_FFFF_FFFF_FFF0 - W'(i);
        dat[14] = 64'h8000_0000_0000_0000;
        dat[15] = 64'h7FFF_FFFF_FFFF_FFFF;
        applyStimulus(1'b0, 8'd50, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < MAX_TAU; i++) dat[i] = W'($urandom_range(0, 3000));
            applyStimulus(1'(r), 8'($urandom_range(1, 40)), W'($urandom_range(500, 2000)),
                          1'b1, 1'(r % 3 == 0), -1);
        end

        checkOutput("scoreboardEmpty", 80'(sbQueue.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/yin_tau_search.md
YIN_TAU_SEARCH -- requirements
Module: yin_tau_search

Interface
REQ-001 The block SHALL have parameter INTERMEDIATE_DATA_WIDTH, default 64: width of the dt' samples and of the average.
REQ-002 The block SHALL have parameter MAX_TAU, default 40: number of dt' samples per search, indices 0..MAX_TAU-1.
REQ-003 The block SHALL have parameter MIN_TAU, default 2: samples with index < MIN_TAU are consumed but never become candidates.
REQ-004 The block SHALL have parameter TAU_BITS, default 8: width of tau outputs; MAX_TAU <= 2**TAU_BITS.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous active-high reset.
- start  in  1  begin search; sampled only in IDLE.
- mode  in  1  0 = first dip below threshold, 1 = local minimum after first dip.
- thr_pct  in  8  threshold in percent of average.
- average  in  INTERMEDIATE_DATA_WIDTH  mean dt' value.
- dval_valid  in  1  dt' sample valid.
- dval  in  INTERMEDIATE_DATA_WIDTH  dt' sample, in index order.
- dval_ready  out  1  block accepts a sample this cycle.
- busy  out  1  search in progress.
- done  out  1  one-cycle result strobe.
- periodic  out  1  result came from a threshold crossing.
- min_tau  out  TAU_BITS  selected tau.
- min_val  out  INTERMEDIATE_DATA_WIDTH  dt' value at min_tau.

Function
REQ-006 On start in IDLE, the block SHALL latch mode, thr_pct and average, clear the index and the candidates, and enter SCAN on the next cycle.
REQ-007 A sample SHALL be accepted when dval_valid and dval_ready are both high; dval_ready SHALL be 1 exactly in SCAN, DESCEND and DRAIN.
REQ-008 The sample index SHALL increment by one per accepted sample, independent of state.
REQ-009 Threshold test SHALL be dval*100 < average*thr_pct, evaluated at full precision (INTERMEDIATE_DATA_WIDTH+8 bits), with no divider and no truncation.
REQ-010 In SCAN, for index >= MIN_TAU, the block SHALL track the global minimum; on ties it SHALL keep the lower index.
REQ-011 In SCAN, on the first sample with index >= MIN_TAU passing the threshold:
- mode 0: set min_tau/min_val to that sample and periodic=1, then go to DRAIN.
- mode 1: load that sample as candidate and go to DESCEND.
REQ-012 In DESCEND, a sample strictly below the candidate SHALL replace the candidate. Otherwise the candidate SHALL be final (periodic=1) and the state SHALL go to DRAIN.
REQ-013 In DRAIN, remaining samples SHALL be accepted and discarded.
REQ-014 When the sample with index MAX_TAU-1 is accepted, the state SHALL go to DONE from any of SCAN, DESCEND or DRAIN. That sample SHALL be evaluated first.
REQ-015 If SCAN ends without a crossing, min_tau/min_val SHALL take the global minimum with periodic=0.
REQ-016 If DESCEND ends at the last sample, the candidate SHALL be final with periodic=1.
REQ-017 DONE SHALL assert done for exactly one cycle, one cycle after the final sample is accepted, then return to IDLE.
REQ-018 min_tau, min_val and periodic SHALL hold until the next start is accepted.
REQ-019 busy SHALL be 1 in every state except IDLE. start while busy SHALL be ignored.
REQ-020 start asserted in the same cycle as done SHALL be ignored; it is honoured in IDLE only.
REQ-021 Stalls on dval_valid=0 SHALL change no state or index, for any duration.
REQ-022 thr_pct=0 SHALL never produce a crossing, so the result is the global minimum with periodic=0.
REQ-023 average=0 SHALL never produce a crossing.
REQ-024 The states SHALL be exactly IDLE, SCAN, DESCEND, DRAIN and DONE.

Reset
REQ-025 While reset is high, the block SHALL asynchronously force state IDLE, index 0, and done, busy, dval_ready, periodic, min_tau and min_val to 0.
REQ-026 Reset asserted mid-search SHALL abort the search, with no done pulse.
REQ-027 After reset, the first start SHALL run a complete fresh search.

Verification
REQ-028 mode0, avg=1000, thr=10, dval=[900,800,500,90,50,40,...,600] -> min_tau=3, min_val=90, periodic=1, done after sample 39 accepted.
REQ-029 mode1, same data, rising after index 5 -> min_tau=5, min_val=40, periodic=1.
REQ-030 mode1, all samples >=100 with minima 150 at indices 7 and 20 -> min_tau=7, min_val=150, periodic=0.
REQ-031 dval=50 at index 1 only, others 500 -> index 1 ignored (below MIN_TAU), periodic=0, min_tau=2.
REQ-032 Random dval_valid gaps, plus start pulsed during SCAN -> same result as the gap-free run, exactly one done pulse.
REQ-033 Reset asserted at index 12 -> outputs 0 immediately, no done; a following start gives a correct full result.
